// File: rtl/issue_hazard_ctrl.sv
// Instruction issue controller for the 3-stage pipeline (no forwarding).
// Buffers fetched instructions in a small FIFO and holds the head back with
// NOP bubbles while it would read a register whose writeback is still in
// flight in the last HAZ_WINDOW issue slots.
// Optional feature: define ISSUE_STALL_COUNT_EN to build a saturating
// counter of hazard bubbles on stall_count; otherwise it is tied to zero.
module issue_hazard_ctrl #(
   parameter int          FIFO_DEPTH = 4,
   parameter int          HAZ_WINDOW = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
   parameter int          WE_BIT     = 31,
   parameter int          DS_BIT     = 30,
   parameter int          RD_LSB     = 21,
   parameter int          RS1_LSB    = 16,
   parameter int          RS2_LSB    = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_instr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [31:0] out_instr,
   output logic        out_issue,
   output logic        busy,
   output logic [15:0] stall_count
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   logic [31:0]           mem_q [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
   logic [AW:0]           count_q, count_d;
   logic [HAZ_WINDOW-1:0] sb_we_q;
   logic [4:0]            sb_rd_q [HAZ_WINDOW];
   logic [31:0]           out_instr_q;
   logic                  out_issue_q;

   logic        full, empty, push, pop, hazard;
   logic [31:0] head;
   logic [4:0]  head_rs1, head_rs2;
   logic        head_ds;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign in_ready = !full && !flush && !rst;
   assign push     = in_valid && in_ready;

   assign head     = mem_q[rd_ptr_q];
   assign head_rs1 = head[RS1_LSB +: 5];
   assign head_rs2 = head[RS2_LSB +: 5];
   assign head_ds  = head[DS_BIT];

   // RAW check of the head against every in-flight writer in the window
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_WINDOW; i++) begin
         if (sb_we_q[i] && (sb_rd_q[i] == head_rs1 ||
                            (!head_ds && sb_rd_q[i] == head_rs2)))
            hazard = 1'b1;
      end
   end

   assign pop     = !flush && !empty && !hazard;
   assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

   // FIFO storage carries no reset; occupancy is tracked by count_q
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_instr;
   end

   // Pointers, occupancy, issue slot and scoreboard shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         out_instr_q <= NOP_INSTR;
         out_issue_q <= 1'b0;
         sb_we_q     <= '0;
         for (int i = 0; i < HAZ_WINDOW; i++) sb_rd_q[i] <= '0;
      end else if (flush) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         out_instr_q <= NOP_INSTR;
         out_issue_q <= 1'b0;
         sb_we_q     <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q     <= count_d;
         out_instr_q <= pop ? head : NOP_INSTR;
         out_issue_q <= pop;
         // slot 0 is the instruction just driven; a bubble never writes
         for (int i = HAZ_WINDOW-1; i > 0; i--) begin
            sb_we_q[i] <= sb_we_q[i-1];
            sb_rd_q[i] <= sb_rd_q[i-1];
         end
         sb_we_q[0] <= pop && head[WE_BIT];
         sb_rd_q[0] <= head[RD_LSB +: 5];
      end
   end

   assign out_instr = out_instr_q;
   assign out_issue = out_issue_q;
   assign busy      = !empty || (|sb_we_q);

`ifdef ISSUE_STALL_COUNT_EN
   logic [15:0] stall_cnt_q;
   logic        stall;

   // only bubbles forced by a real hazard count; an empty FIFO is not a stall
   assign stall = !flush && !empty && hazard;

   // Saturating stall counter, kept across flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt_q <= '0;
      else if (stall && stall_cnt_q != 16'hFFFF)
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stall_count = stall_cnt_q;
`else
   assign stall_count = 16'h0000;
`endif

endmodule
